stack_exec: RTL and testbench

//  Operand stack and sequencer feeding the bit-serial-chain alu (ports a, b, s -> out, cout).

---
 rtl/stack_exec.sv | 154 +++++++++++++++
 tb/tb_stack_exec.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/stack_exec.sv
// Operand stack and sequencer for the external bit-serial alu.
// Non-ALU commands complete in the accept cycle; ALU commands spend one WAIT cycle for writeback.
module stack_exec #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 8,
   localparam int unsigned DW = $clog2(DEPTH + 1),
   localparam int unsigned AW = $clog2(DEPTH)
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_cmd_valid,
   output logic             o_cmd_ready,
   input  logic [2:0]       i_cmd_op,
   input  logic [2:0]       i_cmd_alu_s,
   input  logic [WIDTH-1:0] i_cmd_imm,
   output logic [WIDTH-1:0] o_alu_a,
   output logic [WIDTH-1:0] o_alu_b,
   output logic [2:0]       o_alu_s,
   input  logic [WIDTH-1:0] i_alu_out,
   input  logic             i_alu_cout,
   output logic [WIDTH-1:0] o_tos,
   output logic [DW-1:0]    o_depth,
   output logic             o_flag,
   output logic             o_err_under,
   output logic             o_err_over
);

   typedef enum logic [0:0] {StIdle, StWait} state_e;

   localparam logic [2:0] OpPush   = 3'b001;
   localparam logic [2:0] OpPop    = 3'b010;
   localparam logic [2:0] OpDup    = 3'b011;
   localparam logic [2:0] OpSwap   = 3'b100;
   localparam logic [2:0] OpAlu    = 3'b101;
   localparam logic [2:0] OpClrErr = 3'b110;

   state_e           r_state;
   logic [WIDTH-1:0] r_stack [DEPTH];
   logic [DW-1:0]    r_depth;
   logic             r_flag;
   logic             r_err_under;
   logic             r_err_over;
   logic [WIDTH-1:0] r_alu_a;
   logic [WIDTH-1:0] r_alu_b;
   logic [2:0]       r_alu_s;

   logic [DW-1:0]    w_dm1;
   logic [DW-1:0]    w_dm2;
   logic [AW-1:0]    w_top_idx;
   logic [AW-1:0]    w_nos_idx;
   logic [AW-1:0]    w_push_idx;
   logic             w_empty;
   logic             w_full;
   logic             w_lt2;
   logic [WIDTH-1:0] w_tos;
   logic [WIDTH-1:0] w_nos;

   assign w_dm1      = r_depth - DW'(1);
   assign w_dm2      = r_depth - DW'(2);
   assign w_top_idx  = w_dm1[AW-1:0];
   assign w_nos_idx  = w_dm2[AW-1:0];
   assign w_push_idx = r_depth[AW-1:0];
   assign w_empty    = (r_depth == '0);
   assign w_full     = (r_depth == DW'(DEPTH));
   assign w_lt2      = (r_depth < DW'(2));
   assign w_tos      = w_empty ? '0 : r_stack[w_top_idx];
   assign w_nos      = r_stack[w_nos_idx];

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= StIdle;
         r_depth     <= '0;
         r_flag      <= 1'b0;
         r_err_under <= 1'b0;
         r_err_over  <= 1'b0;
         r_alu_a     <= '0;
         r_alu_b     <= '0;
         r_alu_s     <= '0;
      end else begin
         unique case (r_state)
            StIdle: begin
               if (i_cmd_valid) begin
                  // Failed preconditions still consume the command; only an error bit changes.
                  case (i_cmd_op)
                     OpPush: begin
                        if (w_full) begin
                           r_err_over <= 1'b1;
                        end else begin
                           r_stack[w_push_idx] <= i_cmd_imm;
                           r_depth             <= r_depth + DW'(1);
                        end
                     end
                     OpPop: begin
                        if (w_empty) r_err_under <= 1'b1;
                        else         r_depth     <= w_dm1;
                     end
                     OpDup: begin
                        if (w_empty) begin
                           r_err_under <= 1'b1;
                        end else if (w_full) begin
                           r_err_over <= 1'b1;
                        end else begin
                           r_stack[w_push_idx] <= w_tos;
                           r_depth             <= r_depth + DW'(1);
                        end
                     end
                     OpSwap: begin
                        if (w_lt2) begin
                           r_err_under <= 1'b1;
                        end else begin
                           r_stack[w_top_idx] <= w_nos;
                           r_stack[w_nos_idx] <= w_tos;
                        end
                     end
                     OpAlu: begin
                        if (w_lt2) begin
                           r_err_under <= 1'b1;
                        end else begin
                           r_alu_a <= w_nos;
                           r_alu_b <= w_tos;
                           r_alu_s <= i_cmd_alu_s;
                           r_state <= StWait;
                        end
                     end
                     OpClrErr: begin
                        r_err_under <= 1'b0;
                        r_err_over  <= 1'b0;
                     end
                     default: ;
                  endcase
               end
            end
            StWait: begin
               r_stack[w_nos_idx] <= i_alu_out;
               r_depth            <= w_dm1;
               r_flag             <= i_alu_cout;
               r_state            <= StIdle;
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign o_cmd_ready = (r_state == StIdle);
   assign o_alu_a     = r_alu_a;
   assign o_alu_b     = r_alu_b;
   assign o_alu_s     = r_alu_s;
   assign o_tos       = w_tos;
   assign o_depth     = r_depth;
   assign o_flag      = r_flag;
   assign o_err_under = r_err_under;
   assign o_err_over  = r_err_over;

endmodule

// File: tb/tb_stack_exec.sv
// Directed bench for stack_exec with a small behavioural alu model on the operand ports.
module tb_stack_exec;

   localparam int unsigned WIDTH = 32;
   localparam int unsigned DEPTH = 8;
   localparam int unsigned DW    = $clog2(DEPTH + 1);

   logic             clk;
   logic             rst;
   logic             cmd_valid;
   logic             cmd_ready;
   logic [2:0]       cmd_op;
   logic [2:0]       cmd_alu_s;
   logic [WIDTH-1:0] cmd_imm;
   logic [WIDTH-1:0] alu_a;
   logic [WIDTH-1:0] alu_b;
   logic [2:0]       alu_s;
   logic [WIDTH-1:0] alu_out;
   logic             alu_cout;
   logic [WIDTH-1:0] tos;
   logic [DW-1:0]    depth;
   logic             flag;
   logic             err_under;
   logic             err_over;

   int checks = 0;
   int errors = 0;

   stack_exec #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_cmd_valid (cmd_valid),
      .o_cmd_ready (cmd_ready),
      .i_cmd_op    (cmd_op),
      .i_cmd_alu_s (cmd_alu_s),
      .i_cmd_imm   (cmd_imm),
      .o_alu_a     (alu_a),
      .o_alu_b     (alu_b),
      .o_alu_s     (alu_s),
      .i_alu_out   (alu_out),
      .i_alu_cout  (alu_cout),
      .o_tos       (tos),
      .o_depth     (depth),
      .o_flag      (flag),
      .o_err_under (err_under),
      .o_err_over  (err_over)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Stand-in alu: 010 add, 011 subtract (cout = borrow), 101 xnor (cout = equal).
   always_comb begin
      alu_out  = '0;
      alu_cout = 1'b0;
      case (alu_s)
         3'b010: {alu_cout, alu_out} = {1'b0, alu_a} + {1'b0, alu_b};
         3'b011: begin
            alu_out  = alu_a - alu_b;
            alu_cout = (alu_a < alu_b);
         end
         3'b101: begin
            alu_out  = ~(alu_a ^ alu_b);
            alu_cout = (alu_a == alu_b);
         end
         default: ;
      endcase
   end

   task automatic chk(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
      checks++;
      assert (got === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic issue(input logic [2:0] op, input logic [WIDTH-1:0] imm, input logic [2:0] s);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_imm   = imm;
      cmd_alu_s = s;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      cmd_op    = 3'b000;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst       = 1'b1;
      cmd_valid = 1'b0;
      cmd_op    = 3'b000;
      cmd_alu_s = 3'b000;
      cmd_imm   = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("reset_depth", WIDTH'(depth), 0);
      chk("reset_tos", tos, 0);
      chk("reset_flag", WIDTH'(flag), 0);
      chk("reset_err_under", WIDTH'(err_under), 0);
      chk("reset_err_over", WIDTH'(err_over), 0);
      chk("reset_ready", WIDTH'(cmd_ready), 1);
      chk("reset_alu_a", alu_a, 0);

      // 5 + 3
      issue(3'b001, 5, 0);
      issue(3'b001, 3, 0);
      issue(3'b101, 0, 3'b010);
      chk("add_wait_ready", WIDTH'(cmd_ready), 0);
      chk("add_alu_a", alu_a, 5);
      chk("add_alu_b", alu_b, 3);
      chk("add_alu_s", WIDTH'(alu_s), 2);
      tick();
      chk("add_ready_back", WIDTH'(cmd_ready), 1);
      chk("add_tos", tos, 8);
      chk("add_depth", WIDTH'(depth), 1);
      chk("add_flag", WIDTH'(flag), 0);
      issue(3'b010, 0, 0);

      // 3 - 5
      issue(3'b001, 3, 0);
      issue(3'b001, 5, 0);
      issue(3'b101, 0, 3'b011);
      tick();
      chk("sub_tos", tos, 32'hFFFF_FFFE);
      chk("sub_flag", WIDTH'(flag), 1);
      chk("sub_depth", WIDTH'(depth), 1);
      issue(3'b010, 0, 0);

      // 7 xnor 7
      issue(3'b001, 7, 0);
      issue(3'b001, 7, 0);
      issue(3'b101, 0, 3'b101);
      tick();
      chk("xnor_tos", tos, 32'hFFFF_FFFF);
      chk("xnor_flag", WIDTH'(flag), 1);

      // Reset in the WAIT cycle abandons the writeback
      issue(3'b001, 4, 0);
      issue(3'b001, 4, 0);
      issue(3'b101, 0, 3'b010);
      chk("rstwait_in_wait", WIDTH'(cmd_ready), 0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rstwait_depth", WIDTH'(depth), 0);
      chk("rstwait_flag", WIDTH'(flag), 0);
      chk("rstwait_ready", WIDTH'(cmd_ready), 1);
      chk("rstwait_tos", tos, 0);

      // Command held valid through WAIT is taken in the following IDLE cycle
      issue(3'b001, 10, 0);
      issue(3'b001, 20, 0);
      cmd_valid = 1'b1;
      cmd_op    = 3'b101;
      cmd_alu_s = 3'b010;
      tick();
      chk("held_wait_ready", WIDTH'(cmd_ready), 0);
      cmd_op  = 3'b001;
      cmd_imm = 99;
      tick();
      chk("held_wb_depth", WIDTH'(depth), 1);
      chk("held_wb_tos", tos, 30);
      tick();
      cmd_valid = 1'b0;
      cmd_op    = 3'b000;
      chk("held_push_depth", WIDTH'(depth), 2);
      chk("held_push_tos", tos, 99);
      issue(3'b010, 0, 0);
      issue(3'b010, 0, 0);

      // Fill to DEPTH, then overflow
      for (int i = 1; i <= 8; i++) issue(3'b001, WIDTH'(i), 0);
      issue(3'b001, 9, 0);
      chk("over_depth", WIDTH'(depth), 8);
      chk("over_tos", tos, 8);
      chk("over_err", WIDTH'(err_over), 1);
      issue(3'b011, 0, 0);
      chk("over_dup_depth", WIDTH'(depth), 8);
      issue(3'b110, 0, 0);
      chk("clrerr_over", WIDTH'(err_over), 0);
      for (int i = 0; i < 8; i++) issue(3'b010, 0, 0);
      chk("drain_depth", WIDTH'(depth), 0);

      // Underflow on an empty stack
      issue(3'b010, 0, 0);
      issue(3'b101, 0, 3'b011);
      chk("under_no_wait", WIDTH'(cmd_ready), 1);
      issue(3'b100, 0, 0);
      chk("under_depth", WIDTH'(depth), 0);
      chk("under_err", WIDTH'(err_under), 1);
      chk("under_alu_a", alu_a, 10);
      chk("under_alu_b", alu_b, 20);
      chk("under_alu_s", WIDTH'(alu_s), 2);
      issue(3'b011, 0, 0);
      chk("under_dup_depth", WIDTH'(depth), 0);
      issue(3'b110, 0, 0);
      chk("clrerr_under", WIDTH'(err_under), 0);

      // SWAP / DUP / POP
      issue(3'b001, 1, 0);
      issue(3'b001, 2, 0);
      issue(3'b100, 0, 0);
      issue(3'b011, 0, 0);
      chk("swapdup_tos", tos, 1);
      chk("swapdup_depth", WIDTH'(depth), 3);
      issue(3'b010, 0, 0);
      issue(3'b010, 0, 0);
      chk("pop_tos", tos, 2);
      chk("pop_depth", WIDTH'(depth), 1);
      issue(3'b111, 0, 0);
      chk("nop_depth", WIDTH'(depth), 1);
      chk("flag_kept", WIDTH'(flag), 0);
      chk("no_err", WIDTH'({err_under, err_over}), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
